// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-side PC sequencer.
//   INSN_BYTES   : fixed instruction size, sequential fetch step
//   ctr_t        : 2-bit saturating branch counter encodings
//   btb_entry_t  : one BTB entry, sized for the default configuration
//   sat_update   : saturating counter step toward taken / not-taken
package pc_seq_pkg;

    localparam int unsigned INSN_BYTES    = 4;
    localparam int unsigned DEF_ADDR_W    = 64;
    localparam int unsigned DEF_BTB_DEPTH = 16;
    localparam int unsigned DEF_IDX_W     = $clog2(DEF_BTB_DEPTH);
    localparam int unsigned DEF_TAG_W     = DEF_ADDR_W - 2 - DEF_IDX_W;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_ADDR_W-1:0] target;
        ctr_t                  ctr;
    } btb_entry_t;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t r;
        r = ctr;
        if (taken) begin
            if (ctr != ST) r = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) r = ctr_t'(ctr - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_btb.sv
// Direct-mapped branch target buffer storage.
//   clk, rst_n          : clock, async active-low reset (clears valid and counters)
//   rd_idx -> rd_*      : combinational read port for the fetch lookup
//   up_idx -> up_*      : combinational read port for the resolve-side update
//   wr_en, wr_idx, wr_* : synchronous write of a whole entry (always marked valid)
// Reads return pre-write contents; a write is visible from the next cycle.
module btb_table
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_BTB_DEPTH,
    parameter int unsigned IDX_W  = $clog2(DEPTH),
    parameter int unsigned TAG_W  = ADDR_W - 2 - IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [ADDR_W-1:0] rd_target,
    output logic [1:0]        rd_ctr,
    input  logic [IDX_W-1:0]  up_idx,
    output logic              up_valid,
    output logic [TAG_W-1:0]  up_tag,
    output logic [ADDR_W-1:0] up_target,
    output logic [1:0]        up_ctr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [ADDR_W-1:0] wr_target,
    input  logic [1:0]        wr_ctr
);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        ctr_t              ctr;
    } entry_t;

    entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: SNT};
            end
        end else if (wr_en) begin
            mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: ctr_t'(wr_ctr)};
        end
    end

    always_comb begin
        rd_valid  = mem[rd_idx].valid;
        rd_tag    = mem[rd_idx].tag;
        rd_target = mem[rd_idx].target;
        rd_ctr    = mem[rd_idx].ctr;
        up_valid  = mem[up_idx].valid;
        up_tag    = mem[up_idx].tag;
        up_target = mem[up_idx].target;
        up_ctr    = mem[up_idx].ctr;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side program counter with BTB prediction and branch resolution.
//   CLK, Reset_L          : clock, async active-low reset
//   Stall                 : hold PC (a redirect still wins)
//   CurrentPC             : PC being fetched
//   PredTaken/PredTarget  : BTB prediction for CurrentPC
//   ResolveValid, ResolvePC, SignExtImm64, RegTarget,
//   Branch, BranchNZ, Uncondbranch, RegBranch, ALUZero,
//   ResolvePredTaken/ResolvePredTarget : resolved branch from execute
//   Mispredict            : redirect request to CorrectPC
//   LinkPC                : ResolvePC + 4 for BL
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter int unsigned       BTB_DEPTH = DEF_BTB_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              Stall,
    output logic [ADDR_W-1:0] CurrentPC,
    output logic              PredTaken,
    output logic [ADDR_W-1:0] PredTarget,
    input  logic              ResolveValid,
    input  logic [ADDR_W-1:0] ResolvePC,
    input  logic [ADDR_W-1:0] SignExtImm64,
    input  logic [ADDR_W-1:0] RegTarget,
    input  logic              Branch,
    input  logic              BranchNZ,
    input  logic              Uncondbranch,
    input  logic              RegBranch,
    input  logic              ALUZero,
    input  logic              ResolvePredTaken,
    input  logic [ADDR_W-1:0] ResolvePredTarget,
    output logic              Mispredict,
    output logic [ADDR_W-1:0] LinkPC
);

    localparam int unsigned       IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned       TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSN_BYTES);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] br_target, act_target, correct_pc;
    logic              taken;

    logic [IDX_W-1:0]  fetch_idx, res_idx;
    logic [TAG_W-1:0]  fetch_tag, res_tag;

    logic              rd_valid, up_valid, up_hit;
    logic [TAG_W-1:0]  rd_tag, up_tag;
    logic [ADDR_W-1:0] rd_target, up_target, wr_target;
    logic [1:0]        rd_ctr, up_ctr, wr_ctr;
    logic              wr_en;

    // Resolution
    always_comb begin
        taken      = Uncondbranch | RegBranch | (Branch & ALUZero) | (BranchNZ & ~ALUZero);
        br_target  = ResolvePC + (SignExtImm64 << 2);
        act_target = RegBranch ? RegTarget : br_target;
        LinkPC     = ResolvePC + STEP;
        correct_pc = taken ? act_target : LinkPC;
        Mispredict = Reset_L & ResolveValid &
                     ((taken != ResolvePredTaken) | (taken & (act_target != ResolvePredTarget)));
    end

    // Lookup
    assign fetch_idx  = pc_q[2 +: IDX_W];
    assign fetch_tag  = pc_q[ADDR_W-1 -: TAG_W];
    assign res_idx    = ResolvePC[2 +: IDX_W];
    assign res_tag    = ResolvePC[ADDR_W-1 -: TAG_W];
    assign PredTaken  = rd_valid & (rd_tag == fetch_tag) & rd_ctr[1];
    assign PredTarget = rd_target;
    assign CurrentPC  = pc_q;

    // Training: hits step the counter, taken misses allocate weakly-taken
    always_comb begin
        wr_en     = 1'b0;
        wr_target = up_target;
        wr_ctr    = up_ctr;
        up_hit    = up_valid & (up_tag == res_tag);
        if (ResolveValid) begin
            if (up_hit) begin
                wr_en  = 1'b1;
                wr_ctr = sat_update(ctr_t'(up_ctr), taken);
                if (taken) wr_target = act_target;
            end else if (taken) begin
                wr_en     = 1'b1;
                wr_ctr    = WT;
                wr_target = act_target;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L)        pc_q <= RESET_VEC;
        else if (Mispredict) pc_q <= correct_pc;
        else if (!Stall)     pc_q <= PredTaken ? PredTarget : pc_q + STEP;
    end

    btb_table #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BTB_DEPTH),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
    ) u_btb (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .rd_idx    (fetch_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_ctr    (rd_ctr),
        .up_idx    (res_idx),
        .up_valid  (up_valid),
        .up_tag    (up_tag),
        .up_target (up_target),
        .up_ctr    (up_ctr),
        .wr_en     (wr_en),
        .wr_idx    (res_idx),
        .wr_tag    (res_tag),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr)
    );

endmodule
